// File: rtl/display_pkg.sv
// Shared definitions for the SPI frame loader: opcode encodings and the
// command FSM state type.
package display_pkg;

   // High nibble of a row-load opcode; the low nibble carries the row
   localparam logic [3:0] OP_LOAD_ROW = 4'hF;
   localparam logic [7:0] OP_COMMIT   = 8'h10;
   localparam logic [7:0] OP_BRIGHT   = 8'h20;
   localparam logic [7:0] OP_STATUS   = 8'h30;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      OPCODE   = 3'd1,
      LOAD_COL = 3'd2,
      LOAD     = 3'd3,
      BRIGHT   = 3'd4,
      STATUS   = 3'd5,
      DISCARD  = 3'd6
   } state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully clk-synchronous: synchronises sclk/ss/mosi,
// deserialises bytes MSB-first and serialises a reply byte on miso.
// The ss synchroniser resets to "selected" so that a reset taken while ss is
// already low never fabricates a falling edge; loading resumes on a real fall.
module spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_start,
   output logic       rx_end,
   output logic       miso
);

   logic [2:0] sclk_q_r;
   logic [2:0] ss_q_r;
   logic [1:0] mosi_q_r;
   logic [7:0] shift_r;
   logic [2:0] bit_cnt_r;
   logic [7:0] tx_shift_r;

   logic sclk_rise_s;
   logic sclk_fall_s;
   logic ss_fall_s;
   logic ss_rise_s;
   logic ss_low_s;

   assign sclk_rise_s = sclk_q_r[1] & ~sclk_q_r[2];
   assign sclk_fall_s = ~sclk_q_r[1] & sclk_q_r[2];
   assign ss_fall_s   = ss_q_r[2] & ~ss_q_r[1];
   assign ss_rise_s   = ~ss_q_r[2] & ss_q_r[1];
   assign ss_low_s    = ~ss_q_r[1];
   assign miso        = tx_shift_r[7];

   // Synchronise the SPI pins into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q_r <= 3'b000;
         ss_q_r   <= 3'b000;
         mosi_q_r <= 2'b00;
      end else begin
         sclk_q_r <= {sclk_q_r[1:0], sclk};
         ss_q_r   <= {ss_q_r[1:0], ss};
         mosi_q_r <= {mosi_q_r[0], mosi};
      end
   end

   // Deserialise mosi on sclk rising edges and flag frame start/end
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_start  <= 1'b0;
         rx_end    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_start <= ss_fall_s;
         rx_end   <= ss_rise_s;
         if (!ss_low_s) begin
            bit_cnt_r <= 3'd0;
         end else if (sclk_rise_s) begin
            shift_r   <= {shift_r[6:0], mosi_q_r[1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
               rx_data  <= {shift_r[6:0], mosi_q_r[1]};
               rx_valid <= 1'b1;
            end
         end
      end
   end

   // Reply shifter: shifts on falling edges inside a byte, never on the
   // byte-boundary edge, so a byte loaded between bytes keeps its MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift_r <= 8'h00;
      end else if (tx_load) begin
         tx_shift_r <= tx_data;
      end else if (ss_fall_s) begin
         tx_shift_r <= 8'h00;
      end else if (sclk_fall_s && ss_low_s && (bit_cnt_r != 3'd0)) begin
         tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/spi_frame_loader.sv
// SPI command front-end for an LED panel frame buffer: row/column pixel
// loads, frame commit with flip interlock, brightness and optional status.
// Optional feature macro: SPI_FRAME_LOADER_STATUS_EN (status read-back on
// opcode 0x30; when undefined miso stays 0 and 0x30 is an invalid opcode).
module spi_frame_loader #(
   parameter int SEGMENTS = 1,
   parameter int ROWS     = 8,
   parameter int COLUMNS  = 32,
   parameter int BITWIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sclk,
   input  logic                           ss,
   input  logic                           mosi,
   output logic                           miso,
   output logic [SEGMENTS*BITWIDTH*3-1:0] wdata,
   output logic [$clog2(ROWS)-1:0]        wrow,
   output logic [$clog2(COLUMNS)-1:0]     wcol,
   output logic                           wen,
   input  logic                           ready,
   output logic                           loaded,
   output logic [7:0]                     brightness,
   output logic                           overrun
);
   import display_pkg::*;

   localparam int WD  = SEGMENTS * BITWIDTH * 3;
   localparam int RW  = $clog2(ROWS);
   localparam int CW  = $clog2(COLUMNS);
   localparam int NCH = SEGMENTS * 3;
   localparam int CCW = $clog2(NCH + 1);
   localparam logic [CW-1:0]  COL_LAST  = CW'(COLUMNS - 1);
   localparam logic [CCW-1:0] CHAN_LAST = CCW'(NCH - 1);

   logic [7:0] rx_data_s;
   logic       rx_valid_s;
   logic       rx_start_s;
   logic       rx_end_s;
   logic [7:0] tx_data_s;
   logic       tx_load_s;

   state_e         state_r, state_s;
   logic [CCW-1:0] chan_r, chan_s;
   logic           locked_r, locked_s;
   logic           ready_d_r;
   logic           ready_rise_s;
   logic [WD-1:0]  wdata_s;
   logic [RW-1:0]  wrow_s;
   logic [CW-1:0]  wcol_s;
   logic           wen_s;
   logic           loaded_s;
   logic [7:0]     brightness_s;
   logic           overrun_s;

   spi_slave u_spi (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .ss       (ss),
      .mosi     (mosi),
      .tx_data  (tx_data_s),
      .tx_load  (tx_load_s),
      .rx_data  (rx_data_s),
      .rx_valid (rx_valid_s),
      .rx_start (rx_start_s),
      .rx_end   (rx_end_s),
      .miso     (miso)
   );

   assign ready_rise_s = ready & ~ready_d_r;

   // Register FSM state and every output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         chan_r     <= {CCW{1'b0}};
         locked_r   <= 1'b0;
         ready_d_r  <= 1'b0;
         wdata      <= {WD{1'b0}};
         wrow       <= {RW{1'b0}};
         wcol       <= {CW{1'b0}};
         wen        <= 1'b0;
         loaded     <= 1'b0;
         brightness <= 8'hFF;
         overrun    <= 1'b0;
      end else begin
         state_r    <= state_s;
         chan_r     <= chan_s;
         locked_r   <= locked_s;
         ready_d_r  <= ready;
         wdata      <= wdata_s;
         wrow       <= wrow_s;
         wcol       <= wcol_s;
         wen        <= wen_s;
         loaded     <= loaded_s;
         brightness <= brightness_s;
         overrun    <= overrun_s;
      end
   end

   // Command decode: next state and next register values
   always_comb begin
      state_s      = state_r;
      chan_s       = chan_r;
      wdata_s      = wdata;
      wrow_s       = wrow;
      wcol_s       = wcol;
      wen_s        = 1'b0;
      loaded_s     = 1'b0;
      brightness_s = brightness;
      overrun_s    = overrun;
      tx_load_s    = 1'b0;
      tx_data_s    = 8'h00;

      // A flip-done edge releases the lock; a same-cycle commit overrides it
      if (ready_rise_s) begin
         locked_s = 1'b0;
      end else begin
         locked_s = locked_r;
      end

      // Column advances in the cycle the strobe is visible, so wen sees the old wcol
      if (wen) begin
         if (wcol == COL_LAST) begin
            wcol_s    = {CW{1'b0}};
            overrun_s = 1'b1;
         end else begin
            wcol_s = wcol + CW'(1'b1);
         end
      end else begin
         wcol_s = wcol;
      end

      if (rx_end_s) begin
         state_s = IDLE;
         chan_s  = {CCW{1'b0}};
         if (state_r == STATUS) begin
            overrun_s = 1'b0;
         end else begin
            overrun_s = overrun_s;
         end
      end else if (rx_start_s) begin
         if (state_r == IDLE) begin
            state_s = OPCODE;
         end else begin
            state_s = state_r;
         end
      end else if (rx_valid_s) begin
         case (state_r)
            OPCODE: begin
               if (rx_data_s[7:4] == OP_LOAD_ROW) begin
                  if (32'(rx_data_s[3:0]) < ROWS) begin
                     wrow_s  = RW'(rx_data_s[3:0]);
                     state_s = LOAD_COL;
                  end else begin
                     state_s = DISCARD;
                  end
               end else if (rx_data_s == OP_COMMIT) begin
                  state_s = DISCARD;
                  if (!locked_r || ready_rise_s) begin
                     loaded_s = 1'b1;
                     locked_s = 1'b1;
                  end else begin
                     locked_s = 1'b1;
                  end
               end else if (rx_data_s == OP_BRIGHT) begin
                  state_s = BRIGHT;
`ifdef SPI_FRAME_LOADER_STATUS_EN
               end else if (rx_data_s == OP_STATUS) begin
                  state_s   = STATUS;
                  tx_load_s = 1'b1;
                  tx_data_s = {locked_r, overrun, ready, 1'b0, 4'(wrow)};
`endif
               end else begin
                  state_s = DISCARD;
               end
            end
            LOAD_COL: begin
               wcol_s  = CW'(32'(rx_data_s) % COLUMNS);
               chan_s  = {CCW{1'b0}};
               state_s = LOAD;
            end
            LOAD: begin
               if (locked_r) begin
                  overrun_s = 1'b1;
               end else begin
                  wdata_s = {wdata[WD-9:0], rx_data_s};
                  if (chan_r == CHAN_LAST) begin
                     chan_s = {CCW{1'b0}};
                     wen_s  = 1'b1;
                  end else begin
                     chan_s = chan_r + CCW'(1'b1);
                  end
               end
            end
            BRIGHT: begin
               brightness_s = rx_data_s;
               state_s      = DISCARD;
            end
            STATUS:  state_s = STATUS;
            DISCARD: state_s = DISCARD;
            IDLE:    state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end else begin
         state_s = state_r;
      end
   end

endmodule
